// File: rtl/adpcm_word_unpack_if.sv
// Bus bundle between the serial bitstream source and adpcm_word_unpack.
//   master : bitstream source, drives RATE/SDI/SDI_VALID/FS, observes recovered words
//   slave  : the unpacker, receives the bitstream, drives I/I_VALID/LOCK/SYNC_ERR
interface adpcm_word_unpack_if;
  logic [1:0] RATE;       // codeword size select, 00=2b .. 11=5b
  logic       SDI;        // serial data, MSB first
  logic       SDI_VALID;  // qualifies SDI and FS
  logic       FS;         // frame sync, high with the MSB of each codeword
  logic [4:0] I;          // recovered word, right-justified, zero-extended
  logic       I_VALID;    // one-cycle strobe, I updated
  logic       LOCK;       // word alignment established
  logic       SYNC_ERR;   // one-cycle strobe on a framing error

  modport master (
    output RATE, SDI, SDI_VALID, FS,
    input  I, I_VALID, LOCK, SYNC_ERR
  );

  modport slave (
    input  RATE, SDI, SDI_VALID, FS,
    output I, I_VALID, LOCK, SYNC_ERR
  );
endinterface

// File: rtl/adpcm_word_unpack.sv
// ADPCM codeword deserialiser with frame-sync word alignment.
// Shifts the MSB-first bitstream in, uses FS to find word boundaries and presents each
// 2..5 bit codeword (length RATE+2, RATE latched at the FS bit) on I with a one-cycle
// I_VALID. LOCK rises after LOCK_WORDS consecutive good words; SYNC_ERR pulses on a
// slipped or missing frame sync.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   bus                : slave side of adpcm_word_unpack_if (bitstream in, words out)
//   scan_in0..4/out0..4: five scan chains covering every flop
//   test_mode          : holds the asynchronous reset inactive
//   scan_enable        : selects scan shift instead of functional update
module adpcm_word_unpack #(
  parameter int unsigned LOCK_WORDS = 4,
  parameter int unsigned LCW        = 4
) (
  input  logic               clk,
  input  logic               reset,
  adpcm_word_unpack_if.slave bus,
  input  logic               scan_in0,
  input  logic               scan_in1,
  input  logic               scan_in2,
  input  logic               scan_in3,
  input  logic               scan_in4,
  output logic               scan_out0,
  output logic               scan_out1,
  output logic               scan_out2,
  output logic               scan_out3,
  output logic               scan_out4,
  input  logic               test_mode,
  input  logic               scan_enable
);

  typedef enum logic {StHunt = 1'b0, StRecv = 1'b1} state_e;

  // Every flop lives in this one record so the scan chains can be threaded through it.
  typedef struct packed {
    state_e           st;
    logic [2:0]       cnt;
    logic [4:0]       sh;
    logic [1:0]       rate;
    logic [4:0]       i;
    logic             iv;
    logic             lock;
    logic             serr;
    logic [LCW-1:0]   lcnt;
  } regs_t;

  localparam int unsigned W = $bits(regs_t);

  regs_t         r_q, r_d, func_d;
  logic [W-1:0]  cur, scan_d;
  logic [4:0]    scan_in_v, scan_out_v;
  logic          rst_n_int;

  logic [2:0]     n_len, cnt_inc;
  logic [4:0]     sh_inc;
  logic [LCW-1:0] lcnt_inc;

  assign rst_n_int = reset | test_mode;

  assign n_len    = {1'b0, r_q.rate} + 3'd2;
  assign cnt_inc  = r_q.cnt + 3'd1;
  assign sh_inc   = {r_q.sh[3:0], bus.SDI};
  assign lcnt_inc = (r_q.lcnt == LCW'(LOCK_WORDS)) ? r_q.lcnt : r_q.lcnt + 1'b1;

  // Functional next state.
  always_comb begin
    func_d      = r_q;
    func_d.iv   = 1'b0;
    func_d.serr = 1'b0;
    if (bus.SDI_VALID) begin
      unique case (r_q.st)
        StHunt: begin
          if (bus.FS) begin
            func_d.sh   = {4'b0, bus.SDI};
            func_d.cnt  = 3'd1;
            func_d.rate = bus.RATE;
            func_d.st   = StRecv;
          end
        end
        StRecv: begin
          if (bus.FS) begin
            // cnt is cleared on completion, so a nonzero count here is always a slip.
            if (r_q.cnt != 3'd0) begin
              func_d.serr = 1'b1;
              func_d.lock = 1'b0;
              func_d.lcnt = '0;
            end
            func_d.sh   = {4'b0, bus.SDI};
            func_d.cnt  = 3'd1;
            func_d.rate = bus.RATE;
          end else if (r_q.cnt == 3'd0) begin
            func_d.serr = 1'b1;
            func_d.lock = 1'b0;
            func_d.lcnt = '0;
            func_d.st   = StHunt;
          end else begin
            func_d.sh  = sh_inc;
            func_d.cnt = cnt_inc;
            if (cnt_inc == n_len) begin
              // sh was zeroed at word start, so the upper bits are already zero.
              func_d.i    = sh_inc;
              func_d.iv   = 1'b1;
              func_d.cnt  = 3'd0;
              func_d.lcnt = lcnt_inc;
              if (lcnt_inc == LCW'(LOCK_WORDS)) func_d.lock = 1'b1;
            end
          end
        end
        default: func_d.st = StHunt;
      endcase
    end
  end

  // Chain k holds bits k, k+5, k+10, ...; enters at the low bit, exits at the highest.
  assign scan_in_v = {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0};
  assign cur       = r_q;

  always_comb begin
    scan_d     = '0;
    scan_out_v = '0;
    for (int j = 0; j < 5; j++) scan_d[j] = scan_in_v[j];
    for (int j = 5; j < int'(W); j++) scan_d[j] = cur[j-5];
    for (int j = 0; j < int'(W); j++) scan_out_v[j%5] = cur[j];
  end

  assign {scan_out4, scan_out3, scan_out2, scan_out1, scan_out0} = scan_out_v;

  assign r_d = scan_enable ? regs_t'(scan_d) : func_d;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) r_q <= '0;
    else            r_q <= r_d;
  end

  assign bus.I        = r_q.i;
  assign bus.I_VALID  = r_q.iv;
  assign bus.LOCK     = r_q.lock;
  assign bus.SYNC_ERR = r_q.serr;

endmodule

// File: doc/adpcm_word_unpack.md
Name: adpcm_word_unpack

Overview:
- Serial receive front-end for the decoder side of the ADPCM datapath.
- Deserialises the MSB-first ADPCM codeword bitstream and recovers word alignment from a frame-sync strobe.
- Presents each recovered codeword as a right-justified 5-bit I word, with a one-cycle valid strobe, to the decoder's inverse quantizer and adaptive speed control.
- Complements the encoder-side I producer: 2/3/4/5-bit codewords selected by RATE.

Parameters:
- LOCK_WORDS, 4: consecutive correctly framed words needed before LOCK asserts (range 1..15).
- LCW, 4: width of the lock counter.

Ports:
- clk  input  1  block clock
- reset  input  1  asynchronous, active-low reset
- RATE  input  2  codeword size: 00=2b (16k), 01=3b (24k), 10=4b (32k), 11=5b (40k)
- SDI  input  1  serial data bit, MSB of codeword first
- SDI_VALID  input  1  SDI/FS qualify strobe; a bit is consumed only on cycles where it is high
- FS  input  1  frame sync; high with the first (MSB) bit of every codeword
- I  output  5  recovered ADPCM word, right-justified, zero-extended
- I_VALID  output  1  one-cycle strobe, I updated
- LOCK  output  1  alignment established
- SYNC_ERR  output  1  one-cycle strobe on framing error
- scan_in0..scan_in4  input  1 each  DFT scan chain inputs
- scan_out0..scan_out4  output  1 each  DFT scan chain outputs
- test_mode, scan_enable  input  1 each  DFT controls

Behaviour:
- Reset (reset=0, asynchronous): I=0, I_VALID=0, LOCK=0, SYNC_ERR=0, state=HUNT, bit count=0, lock count=0, shift register=0, latched rate=00.
  - Reset mid-word discards the partial word. No I_VALID is issued for it.
- Cycles with SDI_VALID=0: no state change. I_VALID and SYNC_ERR return to 0. Gaps of any length between bits are legal.
- Codeword length N = RATE+2. RATE is latched only on the FS bit that starts a word; RATE changes mid-word have no effect until the next FS bit.
- HUNT state:
  - Bits with FS=0 are discarded.
  - A bit with SDI_VALID=1 and FS=1: shift register <= SDI, count <= 1, latch RATE, go to RECV.
  - No SYNC_ERR is raised while in HUNT.
- RECV state, for each valid bit:
  - FS=1 with 0<count<N (slip): SYNC_ERR=1 for one cycle, LOCK<=0, lock count<=0. The bit restarts a new word (count<=1, RATE relatched). State stays RECV.
  - FS=0 with count=0 (missing sync on a word-start bit): SYNC_ERR=1, LOCK<=0, lock count<=0, bit discarded, go to HUNT.
  - FS=1 with count=0: normal word start. Shift register <= SDI, count<=1, RATE relatched.
  - Otherwise: shift register <= {shift, SDI}, count <= count+1.
  - When the bit just consumed makes count=N:
    - On that same clock edge, I <= zero-extended N-bit word and I_VALID=1 for exactly one cycle.
    - count <= 0.
    - Lock count increments, saturating at LOCK_WORDS; LOCK<=1 on the edge it reaches LOCK_WORDS.
  - N=1 is not possible, so a word can never start and complete on the same bit.
- I holds its value between strobes.
- Latency: 0 cycles after the final-bit sampling edge; I_VALID is registered.
- SYNC_ERR and I_VALID are never high in the same cycle.
- A completed word followed immediately by a slip is valid; its I_VALID has already been issued.
- DFT: all flops are on the scan chains. scan_enable selects scan shift. test_mode forces the asynchronous reset inactive during shift.

Test Plan:
- Reset, RATE=10; bits 1,0,1,1 with FS on the first bit -> I=5'b01011, I_VALID high one cycle on the edge of the 4th bit, LOCK=0.
- RATE=11; bits 1,1,0,0,1 with FS on the first, idle cycles (SDI_VALID=0) between bits 2 and 3 -> I=5'b11001, single I_VALID.
- Four consecutive correctly framed RATE=00 words 10,01,11,00 -> I=2,1,3,0; LOCK rises on the 4th I_VALID. Next word-start bit with FS=0 -> SYNC_ERR pulse, LOCK=0, HUNT; the following FS bit resumes reception.
- RATE=10, FS asserted on the 3rd bit of a word -> SYNC_ERR one cycle, no I_VALID. The new word 1,1,1,0 starting at that bit -> I=5'b01110.
- RATE changed 10->01 after the 2nd bit of a word -> that word completes as 4 bits; the next word is decoded as 3 bits.
- reset pulsed low asynchronously after 2 bits of a 5-bit word -> all outputs 0 immediately, no I_VALID, HUNT. A fresh FS word then decodes correctly.
